// File: rtl/bg_pkg.sv
// Shared constants, state encoding and address helper for the background colour RAM.
// pix_addr is also used by the read side, so it must stay multiplier-free.
package bg_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int ADDR_W   = 17;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  function automatic int color_w(input int number_colors);
    return $clog2(number_colors) + 1;
  endfunction

  // Column-major address y + 240*x, built as (x<<8) - (x<<4) + y
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
    logic [ADDR_W-1:0] xs;
    xs = ADDR_W'(x);
    return (xs << 8) - (xs << 4) + ADDR_W'(y);
  endfunction

endpackage

// File: rtl/bg_rect_clip.sv
// Clamps a fill rectangle's far corner to the screen and flags rectangles with no visible pixels.
module bg_rect_clip
  import bg_pkg::*;
(
  input  logic [8:0] i_x0,
  input  logic [7:0] i_y0,
  input  logic [8:0] i_x1,
  input  logic [7:0] i_y1,
  output logic [8:0] o_x1c,
  output logic [7:0] o_y1c,
  output logic       o_empty
);

  assign o_x1c = (i_x1 > 9'(SCREEN_W - 1)) ? 9'(SCREEN_W - 1) : i_x1;
  assign o_y1c = (i_y1 > 8'(SCREEN_H - 1)) ? 8'(SCREEN_H - 1) : i_y1;

  assign o_empty = (i_x0 > o_x1c) || (i_y0 > o_y1c) ||
                   (i_x0 >= 9'(SCREEN_W)) || (i_y0 >= 8'(SCREEN_H));

endmodule

// File: rtl/background_fill.sv
// Rectangle fill engine: accepts clipped fill commands and streams one background RAM write per cycle.
module background_fill
  import bg_pkg::*;
#(
  parameter  int NUMBER_COLORS = 10,
  localparam int CW            = color_w(NUMBER_COLORS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x0,
  input  logic [7:0]        cmd_y0,
  input  logic [8:0]        cmd_x1,
  input  logic [7:0]        cmd_y1,
  input  logic [CW-1:0]     cmd_color,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] waddr,
  output logic [CW-1:0]     din,
  output logic              we
);

  state_t            r_state;
  state_t            w_next;
  logic [8:0]        r_x;
  logic [8:0]        r_x1;
  logic [7:0]        r_y;
  logic [7:0]        r_y0;
  logic [7:0]        r_y1;
  logic [ADDR_W-1:0] r_col_base;
  logic [ADDR_W-1:0] r_waddr;
  logic [CW-1:0]     r_din;
  logic              r_we;

  logic [8:0]        w_x1c;
  logic [7:0]        w_y1c;
  logic              w_empty;
  logic              w_accept;
  logic              w_last;
  logic [ADDR_W-1:0] w_start_addr;
  logic [ADDR_W-1:0] w_next_col;

  bg_rect_clip u_clip (
    .i_x0    (cmd_x0),
    .i_y0    (cmd_y0),
    .i_x1    (cmd_x1),
    .i_y1    (cmd_y1),
    .o_x1c   (w_x1c),
    .o_y1c   (w_y1c),
    .o_empty (w_empty)
  );

  assign cmd_ready    = (r_state == IDLE) && rst_n;
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_last       = (r_x == r_x1) && (r_y == r_y1);
  assign w_start_addr = pix_addr(cmd_x0, cmd_y0);
  assign w_next_col   = r_col_base + ADDR_W'(SCREEN_H);

  assign busy  = (r_state == FILL);
  assign done  = (r_state == DONE);
  assign waddr = r_waddr;
  assign din   = r_din;
  assign we    = r_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_empty ? DONE : FILL;
      FILL:    if (abort) w_next = IDLE;
               else if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The output registers always hold the pixel being written; r_x/r_y track that pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_x1       <= '0;
      r_y        <= '0;
      r_y0       <= '0;
      r_y1       <= '0;
      r_col_base <= '0;
      r_waddr    <= '0;
      r_din      <= '0;
      r_we       <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && !w_empty) begin
            r_x        <= cmd_x0;
            r_x1       <= w_x1c;
            r_y        <= cmd_y0;
            r_y0       <= cmd_y0;
            r_y1       <= w_y1c;
            r_col_base <= w_start_addr;
            r_waddr    <= w_start_addr;
            r_din      <= cmd_color;
            r_we       <= 1'b1;
          end
        end
        FILL: begin
          if (!abort && !w_last) begin
            r_we <= 1'b1;
            if (r_y == r_y1) begin
              r_x        <= r_x + 9'd1;
              r_y        <= r_y0;
              r_col_base <= w_next_col;
              r_waddr    <= w_next_col;
            end else begin
              r_y     <= r_y + 8'd1;
              r_waddr <= r_waddr + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_background_fill.sv
// Scenario bench for background_fill: directed test-plan cases, randomized rectangles
// against a loop-based fill model, abort, reset mid-fill and back-to-back full-screen fill.
module tb_background_fill;

  localparam int SW = 320;
  localparam int SH = 240;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x0;
  logic [7:0]  cmd_y0;
  logic [8:0]  cmd_x1;
  logic [7:0]  cmd_y1;
  logic [4:0]  cmd_color;
  logic        abort;
  logic        busy;
  logic        done;
  logic [16:0] waddr;
  logic [4:0]  din;
  logic        we;

  int total = 0;
  int bad   = 0;

  int obs_addr[$];
  int obs_din[$];
  int exp_addr[$];
  int first_idx;
  int done_idx;
  int bubbles;
  int ready_hi;
  int done_we;
  int busy_bad;
  bit hs_ok;

  background_fill #(.NUMBER_COLORS(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_x1    (cmd_x1),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .waddr     (waddr),
    .din       (din),
    .we        (we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: clip with min(), then walk columns outer, rows inner
  task automatic model_fill(input int x0, input int y0, input int x1, input int y1);
    int x1c;
    int y1c;
    exp_addr.delete();
    x1c = (x1 < SW) ? x1 : SW - 1;
    y1c = (y1 < SH) ? y1 : SH - 1;
    if (x0 >= SW || y0 >= SH || x0 > x1c || y0 > y1c) return;
    for (int x = x0; x <= x1c; x++)
      for (int y = y0; y <= y1c; y++)
        exp_addr.push_back(y + SH * x);
  endtask

  function automatic int seq_diff();
    int n;
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++)
      if (obs_addr[i] != exp_addr[i]) return i;
    return -1;
  endfunction

  function automatic int din_errors(input int c);
    int e = 0;
    foreach (obs_din[i]) if (obs_din[i] != c) e++;
    return e;
  endfunction

  task automatic send_cmd(input int x0, input int y0, input int x1, input int y1, input int c);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    hs_ok     = (cmd_ready === 1'b1);
    cmd_x0    = 9'(x0);
    cmd_y0    = 8'(y0);
    cmd_x1    = 9'(x1);
    cmd_y1    = 8'(y1);
    cmd_color = 5'(c);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Entered in the first cycle after the accept edge; returns while sitting in the done cycle
  task automatic collect(input int budget);
    obs_addr.delete();
    obs_din.delete();
    first_idx = -1;
    done_idx  = -1;
    bubbles   = 0;
    ready_hi  = 0;
    done_we   = 0;
    busy_bad  = 0;
    for (int idx = 1; idx <= budget; idx++) begin
      if (done === 1'b1) begin
        if (we === 1'b1) done_we++;
        done_idx = idx;
        break;
      end
      if (we === 1'b1) begin
        if (first_idx < 0) first_idx = idx;
        obs_addr.push_back(int'(waddr));
        obs_din.push_back(int'(din));
        if (busy !== 1'b1) busy_bad++;
      end else begin
        bubbles++;
      end
      if (cmd_ready === 1'b1) ready_hi++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({we, busy, done, waddr, din} !== 25'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got we=%b busy=%b done=%b waddr=%0d din=%0d, want all 0", we, busy, done, waddr, din);
    end
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_ready: got %b want 0", cmd_ready);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_after_reset: got %b want 1", cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int cx0[6] = '{5, 0, 318, 10, 330, 3};
    int cy0[6] = '{7, 0, 238, 5, 5, 250};
    int cx1[6] = '{5, 1, 400, 9, 335, 5};
    int cy1[6] = '{7, 2, 255, 5, 6, 255};
    int cc[6]  = '{3, 9, 4, 2, 1, 6};
    int cn[6]  = '{1, 6, 4, 0, 0, 0};
    int cfa[6] = '{1207, 0, 76558, 0, 0, 0};
    int cla[6] = '{1207, 242, 76799, 0, 0, 0};
    int d;
    for (int k = 0; k < 6; k++) begin
      model_fill(cx0[k], cy0[k], cx1[k], cy1[k]);
      send_cmd(cx0[k], cy0[k], cx1[k], cy1[k], cc[k]);
      collect(cn[k] + 6);
      total++;
      if (hs_ok !== 1'b1) begin
        bad++;
        $display("[TB] FAIL dir%0d_handshake: cmd_ready never rose", k);
      end
      total++;
      if (obs_addr.size() != cn[k]) begin
        bad++;
        $display("[TB] FAIL dir%0d_count: got %0d writes want %0d", k, obs_addr.size(), cn[k]);
      end
      d = seq_diff();
      total++;
      if (d >= 0) begin
        bad++;
        $display("[TB] FAIL dir%0d_addr_seq: write %0d got %0d want %0d", k, d, obs_addr[d], exp_addr[d]);
      end
      if (cn[k] > 0 && obs_addr.size() > 0) begin
        total++;
        if (obs_addr[0] != cfa[k] || obs_addr[obs_addr.size()-1] != cla[k]) begin
          bad++;
          $display("[TB] FAIL dir%0d_ends: got first=%0d last=%0d want %0d/%0d", k, obs_addr[0], obs_addr[obs_addr.size()-1], cfa[k], cla[k]);
        end
        total++;
        if (first_idx != 1 || din_errors(cc[k]) != 0) begin
          bad++;
          $display("[TB] FAIL dir%0d_first_write: got cycle=%0d din_errs=%0d want cycle 1, 0 errs", k, first_idx, din_errors(cc[k]));
        end
      end
      total++;
      if (done_idx != cn[k] + 1 || bubbles != 0 || done_we != 0 || ready_hi != 0 || busy_bad != 0) begin
        bad++;
        $display("[TB] FAIL dir%0d_timing: got done_at=%0d bubbles=%0d done_we=%0d ready_in_fill=%0d busy_bad=%0d want done_at=%0d, rest 0",
                 k, done_idx, bubbles, done_we, ready_hi, busy_bad, cn[k] + 1);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL dir%0d_after_done: got done=%b ready=%b want 0/1", k, done, cmd_ready);
      end
    end
  endtask

  task automatic test_random();
    int x0, y0, x1, y1, c, d, errs;
    errs = 0;
    for (int k = 0; k < 24; k++) begin
      x0 = $urandom_range(0, 330);
      y0 = $urandom_range(0, 250);
      x1 = x0 + $urandom_range(0, 6) - 2;
      y1 = y0 + $urandom_range(0, 20) - 3;
      if (x1 < 0) x1 = 0;
      if (y1 < 0) y1 = 0;
      if (y1 > 255) y1 = 255;
      c = $urandom_range(0, 9);
      model_fill(x0, y0, x1, y1);
      send_cmd(x0, y0, x1, y1, c);
      collect(exp_addr.size() + 6);
      d = seq_diff();
      total++;
      if (obs_addr.size() != exp_addr.size() || d >= 0 || din_errors(c) != 0) begin
        bad++;
        $display("[TB] FAIL rand%0d_writes (%0d,%0d)-(%0d,%0d): got %0d writes diff_at=%0d din_errs=%0d want %0d writes",
                 k, x0, y0, x1, y1, obs_addr.size(), d, din_errors(c), exp_addr.size());
      end
      total++;
      if (done_idx != exp_addr.size() + 1 || bubbles != 0) begin
        bad++;
        $display("[TB] FAIL rand%0d_done: got done_at=%0d bubbles=%0d want %0d/0", k, done_idx, bubbles, exp_addr.size() + 1);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    int errs = 0;
    int late = 0;
    model_fill(0, 0, 9, 9);
    send_cmd(0, 0, 9, 9, 6);
    for (int i = 0; i < 10; i++) begin
      if (we !== 1'b1 || int'(waddr) != exp_addr[i]) errs++;
      if (i == 9) abort = 1'b1;
      @(posedge clk); #1;
    end
    abort = 1'b0;
    total++;
    if (errs != 0) begin
      bad++;
      $display("[TB] FAIL abort_prefix: got %0d bad writes in the first 10, want 0", errs);
    end
    total++;
    if (we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort_stop: got we=%b busy=%b done=%b ready=%b want 0/0/0/1", we, busy, done, cmd_ready);
    end
    for (int i = 0; i < 4; i++) begin
      if (we === 1'b1 || done === 1'b1) late++;
      @(posedge clk); #1;
    end
    total++;
    if (late != 0) begin
      bad++;
      $display("[TB] FAIL abort_quiet: got %0d cycles with we/done after abort, want 0", late);
    end
    abort = 1'b1;
    model_fill(20, 20, 20, 22);
    send_cmd(20, 20, 20, 22, 1);
    abort = 1'b0;
    collect(10);
    total++;
    if (obs_addr.size() != 3 || seq_diff() >= 0 || done_idx != 4) begin
      bad++;
      $display("[TB] FAIL abort_idle_ignored: got %0d writes done_at=%0d want 3 writes done_at=4", obs_addr.size(), done_idx);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fill();
    int late = 0;
    send_cmd(0, 0, 4, 4, 2);
    repeat (4) begin
      @(posedge clk); #1;
    end
    total++;
    if (we !== 1'b1 || waddr !== 17'd4) begin
      bad++;
      $display("[TB] FAIL rst_pre: got we=%b waddr=%0d want 1/4", we, waddr);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({we, busy, done, waddr, din, cmd_ready} !== 26'd0) begin
      bad++;
      $display("[TB] FAIL rst_mid_fill: got we=%b busy=%b done=%b waddr=%0d din=%0d ready=%b want all 0",
               we, busy, done, waddr, din, cmd_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (we === 1'b1 || done === 1'b1) late++;
      @(posedge clk); #1;
    end
    total++;
    if (late != 0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_recover: got %0d we/done cycles ready=%b want 0/1", late, cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    int n = 0;
    model_fill(0, 0, 319, 239);
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    cmd_x0 = 9'd0; cmd_y0 = 8'd0; cmd_x1 = 9'd319; cmd_y1 = 8'd239; cmd_color = 5'd5;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_x0 = 9'd2; cmd_y0 = 8'd3; cmd_x1 = 9'd2; cmd_y1 = 8'd4; cmd_color = 5'd7;
    collect(76810);
    d = seq_diff();
    total++;
    if (obs_addr.size() != 76800 || d >= 0) begin
      bad++;
      $display("[TB] FAIL full_writes: got %0d writes diff_at=%0d want 76800, no diff", obs_addr.size(), d);
    end
    total++;
    if (obs_addr.size() == 0 || obs_addr[obs_addr.size()-1] != 76799) begin
      bad++;
      $display("[TB] FAIL full_last_addr: got %0d want 76799", (obs_addr.size() == 0) ? -1 : obs_addr[obs_addr.size()-1]);
    end
    total++;
    if (done_idx != 76801 || bubbles != 0 || ready_hi != 0 || din_errors(5) != 0) begin
      bad++;
      $display("[TB] FAIL full_timing: got done_at=%0d bubbles=%0d ready_in_fill=%0d din_errs=%0d want 76801/0/0/0",
               done_idx, bubbles, ready_hi, din_errors(5));
    end
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || we !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_ready: got ready=%b done=%b we=%b want 1/0/0", cmd_ready, done, we);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    collect(10);
    total++;
    if (obs_addr.size() != 2 || first_idx != 1 || obs_addr[0] != 483 || obs_addr[1] != 484 || din_errors(7) != 0) begin
      bad++;
      $display("[TB] FAIL b2b_second: got %0d writes first_at=%0d want 2 writes 483,484 at cycle 1", obs_addr.size(), first_idx);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_reset_mid_fill();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
